// File: rtl/reg_dump_streamer.sv
// Debug register read-out: walks the core's debug port and emits a framed,
// XOR-checksummed little-endian byte stream over valid/ready.
module reg_dump_streamer #(
   parameter int unsigned NUM_REGS = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [4:0]  reg_out_id,
   input  logic [31:0] reg_out_data,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   typedef enum logic [2:0] {IDLE, SYNC, LOAD, SEND, CSUM, DONE} state_t;

   localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

   state_t      state;
   logic [4:0]  index;
   logic [1:0]  byte_cnt;
   logic [23:0] shift;
   logic [7:0]  csum;
   logic        xfer;

   assign xfer = tx_valid & tx_ready;

   // The low byte of the captured word goes straight into tx_data, so the
   // shift register only needs to hold the three bytes still to come.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         tx_valid   <= 1'b0;
         tx_data    <= '0;
         reg_out_id <= '0;
         index      <= '0;
         byte_cnt   <= '0;
         shift      <= '0;
         csum       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= SYNC;
                  index    <= '0;
                  csum     <= '0;
                  busy     <= 1'b1;
                  tx_valid <= 1'b1;
                  tx_data  <= 8'hA5;
               end
            end
            SYNC: begin
               if (xfer) begin
                  state      <= LOAD;
                  tx_valid   <= 1'b0;
                  reg_out_id <= index;
               end
            end
            LOAD: begin
               state    <= SEND;
               shift    <= reg_out_data[31:8];
               tx_data  <= reg_out_data[7:0];
               tx_valid <= 1'b1;
               byte_cnt <= '0;
            end
            SEND: begin
               if (xfer) begin
                  csum     <= csum ^ tx_data;
                  byte_cnt <= byte_cnt + 2'd1;
                  shift    <= {8'h00, shift[23:8]};
                  if (byte_cnt == 2'd3) begin
                     if (index == LAST_IDX) begin
                        state   <= CSUM;
                        tx_data <= csum ^ tx_data;
                     end else begin
                        state      <= LOAD;
                        index      <= index + 5'd1;
                        reg_out_id <= index + 5'd1;
                        tx_valid   <= 1'b0;
                     end
                  end else begin
                     tx_data <= shift[7:0];
                  end
               end
            end
            CSUM: begin
               if (xfer) begin
                  state    <= DONE;
                  tx_valid <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Randomized bench for reg_dump_streamer: frames are compared against a byte
// list built from the register array, plus cycle-count and stall-hold rules.
module tb_reg_dump_streamer;

   localparam int unsigned NUM_REGS  = 32;
   localparam int          FRAME_CYC = 5 * NUM_REGS + 3;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        busy;
   logic        done;
   logic [4:0]  reg_out_id;
   logic [31:0] reg_out_data;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   logic [31:0] regs [32];
   logic [7:0]  exp_q [$];
   logic [7:0]  got_q [$];
   int          checks = 0;
   int          errors = 0;
   bit          aborted;

   always #5 clock = ~clock;

   // Stand-in for the core's combinational debug read port
   assign reg_out_data = regs[reg_out_id];

   reg_dump_streamer #(.NUM_REGS(NUM_REGS)) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .reg_out_id   (reg_out_id),
      .reg_out_data (reg_out_data),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic build_expected();
      logic [7:0] sum;
      logic [7:0] b;
      sum = 8'h00;
      exp_q = {};
      exp_q.push_back(8'hA5);
      for (int r = 0; r < int'(NUM_REGS); r++) begin
         for (int k = 0; k < 4; k++) begin
            b = 8'(regs[r] >> (8 * k));
            exp_q.push_back(b);
            sum ^= b;
         end
      end
      exp_q.push_back(sum);
   endtask

   task automatic clear_regs();
      for (int r = 0; r < 32; r++) regs[r] = 32'h0;
   endtask

   // Pulses start in the current IDLE cycle and follows the frame; cycle 1 is SYNC.
   task automatic run_frame(input bit random_ready, input bit extra_starts,
                            input int abort_at, output bit was_aborted);
      int         stalls;
      int         busy_cyc;
      int         done_cyc;
      bit         prev_stall;
      logic [7:0] prev_data;
      got_q       = {};
      stalls      = 0;
      busy_cyc    = 0;
      done_cyc    = 0;
      prev_stall  = 1'b0;
      prev_data   = 8'h00;
      was_aborted = 1'b0;
      start       = 1'b1;
      tx_ready    = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      for (int cyc = 1; cyc <= 4000; cyc++) begin
         tx_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         start = extra_starts && (cyc == 1 || cyc == 40 ||
                                  cyc == FRAME_CYC - 1 || cyc == FRAME_CYC);
         @(negedge clock);
         if (prev_stall) begin
            check("hold_valid", 32'(tx_valid), 32'd1);
            check("hold_data", 32'(tx_data), 32'(prev_data));
         end
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
         if (prev_stall) stalls++;
         if (busy) busy_cyc++;
         if (tx_valid && tx_ready) got_q.push_back(tx_data);
         if (done) begin
            done_cyc = cyc;
            break;
         end
         if (abort_at != 0 && got_q.size() == abort_at) begin
            was_aborted = 1'b1;
            break;
         end
         @(posedge clock); #1;
      end
      if (was_aborted) begin
         start = 1'b0;
         return;
      end
      @(posedge clock); #1;
      start = 1'b0;
      check("done_seen", 32'(done_cyc != 0), 32'd1);
      check("done_cycle", 32'(done_cyc), 32'(FRAME_CYC + stalls));
      check("busy_cycles", 32'(busy_cyc), 32'(FRAME_CYC - 1 + stalls));
      check("frame_len", 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b1;
      tx_ready = 1'b1;
      clear_regs();
      regs[5] = 32'hDEAD_BEEF;

      // Power-up reset with start held high throughout
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_valid", 32'(tx_valid), 32'd0);
      check("rst_data", 32'(tx_data), 32'h00);
      check("rst_id", 32'(reg_out_id), 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      start = 1'b0;
      repeat (3) begin
         @(negedge clock);
         check("start_in_reset_ignored", 32'(tx_valid), 32'd0);
      end
      @(posedge clock); #1;

      // Basic dump: x10 = 3
      clear_regs();
      regs[10] = 32'd3;
      build_expected();
      run_frame(1'b0, 1'b0, 0, aborted);

      // Byte order, started in the IDLE cycle right after DONE
      clear_regs();
      regs[1] = 32'h1234_5678;
      regs[2] = 32'hFFFF_FFFF;
      build_expected();
      run_frame(1'b0, 1'b0, 0, aborted);

      // Backpressure on the basic dump, then on random contents
      clear_regs();
      regs[10] = 32'd3;
      build_expected();
      run_frame(1'b1, 1'b0, 0, aborted);
      for (int r = 0; r < 32; r++) regs[r] = $urandom;
      build_expected();
      run_frame(1'b1, 1'b0, 0, aborted);

      // Start pulses while busy and in DONE must not begin a second frame
      clear_regs();
      regs[10] = 32'd3;
      build_expected();
      run_frame(1'b0, 1'b1, 0, aborted);
      repeat (6) begin
         @(negedge clock);
         check("no_second_header", 32'(tx_valid), 32'd0);
         check("no_second_busy", 32'(busy), 32'd0);
      end
      @(posedge clock); #1;

      // Reset after the 50th transfer
      for (int r = 0; r < 32; r++) regs[r] = $urandom;
      build_expected();
      run_frame(1'b1, 1'b0, 50, aborted);
      check("aborted_at_50", 32'(aborted), 32'd1);
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      check("midrst_valid", 32'(tx_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      repeat (10) begin
         @(negedge clock);
         check("midrst_no_done", 32'({done, tx_valid}), 32'd0);
      end
      @(posedge clock); #1;
      run_frame(1'b0, 1'b0, 0, aborted);

      // Reset while idle clears the held checksum byte and register index
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      check("idle_rst_data", 32'(tx_data), 32'h00);
      check("idle_rst_id", 32'(reg_out_id), 32'd0);
      check("idle_rst_valid", 32'(tx_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
